// File: rtl/mult_share_arbiter.sv
// Round-robin front end that time-shares one unsigned array multiplier among
// NUM_REQ clients through an operand stage and a result stage with backpressure.
module mult_share_arbiter #(
    parameter int WIDTH_A = 16,
    parameter int WIDTH_B = 16,
    parameter int NUM_REQ = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*WIDTH_A-1:0]   req_a,
    input  logic [NUM_REQ*WIDTH_B-1:0]   req_b,
    output logic [NUM_REQ-1:0]           rsp_valid,
    output logic [WIDTH_A+WIDTH_B-1:0]   rsp_y,
    input  logic                         rsp_ready,
    output logic                         busy
);

    localparam int PW    = WIDTH_A + WIDTH_B;
    localparam int PTR_W = $clog2(NUM_REQ);

    logic [WIDTH_A-1:0] a_slice [NUM_REQ];
    logic [WIDTH_B-1:0] b_slice [NUM_REQ];

    logic [WIDTH_A-1:0] a_q, a_d;
    logic [WIDTH_B-1:0] b_q, b_d;
    logic [NUM_REQ-1:0] own1_q, own1_d, own2_q, own2_d;
    logic               v1_q, v1_d, v2_q, v2_d;
    logic [PW-1:0]      y_q, y_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;

    logic               grant_any;
    logic [PTR_W-1:0]   grant_idx;
    logic [NUM_REQ-1:0] grant_oh;
    logic               s2_stall, s1_adv, accept_en, transfer;
    logic [PW-1:0]      pp [WIDTH_B];
    logic [PW-1:0]      product;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
            assign a_slice[gi] = req_a[gi*WIDTH_A +: WIDTH_A];
            assign b_slice[gi] = req_b[gi*WIDTH_B +: WIDTH_B];
        end
        // One shifted copy of A per bit of B; the adder chain below sums them.
        for (gi = 0; gi < WIDTH_B; gi++) begin : g_pp
            assign pp[gi] = b_q[gi] ? (PW'(a_q) << gi) : '0;
        end
    endgenerate

    always_comb begin
        product = '0;
        for (int j = 0; j < WIDTH_B; j++) begin
            product = product + pp[j];
        end
    end

    // Scan from the highest offset down so the nearest valid requester at or
    // after ptr_q overwrites any farther one.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            int               idx;
            logic [PTR_W-1:0] idx_w;
            idx = int'(ptr_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            idx_w = PTR_W'(idx);
            if (req_valid[idx_w]) begin
                grant_any = 1'b1;
                grant_idx = idx_w;
            end
        end
    end

    always_comb begin
        grant_oh = '0;
        if (grant_any) begin
            grant_oh[grant_idx] = 1'b1;
        end
    end

    assign s2_stall  = v2_q & ~rsp_ready;
    assign s1_adv    = v1_q & ~s2_stall;
    assign accept_en = ~v1_q | ~s2_stall;
    assign req_ready = (accept_en && rst_n) ? grant_oh : '0;
    assign transfer  = |req_ready;

    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        own1_d = own1_q;
        v1_d   = v1_q;
        y_d    = y_q;
        own2_d = own2_q;
        v2_d   = v2_q;
        ptr_d  = ptr_q;

        if (transfer) begin
            a_d    = a_slice[grant_idx];
            b_d    = b_slice[grant_idx];
            own1_d = grant_oh;
            v1_d   = 1'b1;
            ptr_d  = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end else if (s1_adv) begin
            v1_d = 1'b0;
        end

        if (s1_adv) begin
            y_d    = product;
            own2_d = own1_q;
            v2_d   = 1'b1;
        end else if (v2_q && rsp_ready) begin
            v2_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            own1_q <= '0;
            v1_q   <= 1'b0;
            y_q    <= '0;
            own2_q <= '0;
            v2_q   <= 1'b0;
            ptr_q  <= '0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            own1_q <= own1_d;
            v1_q   <= v1_d;
            y_q    <= y_d;
            own2_q <= own2_d;
            v2_q   <= v2_d;
            ptr_q  <= ptr_d;
        end
    end

    assign rsp_valid = own2_q & {NUM_REQ{v2_q}};
    assign rsp_y     = y_q;
    assign busy      = v1_q | v2_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Bench for mult_share_arbiter: table vectors, directed multi-cycle sequences
// and randomized traffic, all checked against an in-flight queue model.
module tb_mult_share_arbiter;

    localparam int WA = 8;
    localparam int WB = 8;
    localparam int NR = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*WA-1:0]  req_a;
    logic [NR*WB-1:0]  req_b;
    logic [NR-1:0]     rsp_valid;
    logic [WA+WB-1:0]  rsp_y;
    logic              rsp_ready;
    logic              busy;

    mult_share_arbiter #(.WIDTH_A(WA), .WIDTH_B(WB), .NUM_REQ(NR)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_y(rsp_y),
        .rsp_ready(rsp_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [WA-1:0] op_a [NR];
    logic [WB-1:0] op_b [NR];

    // Reference: ops in flight, oldest first; at most two, head may be in the result slot.
    typedef struct {
        int          owner;
        logic [15:0] y;
        bit          in_s2;
    } ent_t;
    ent_t        q[$];
    int          m_ptr = 0;
    logic [15:0] m_y   = '0;

    logic [NR-1:0] last_ready, last_rv;
    logic [15:0]   last_y;
    logic          last_busy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic [NR-1:0] v, input logic rr, input logic rn);
        bit            s2_full, s1_full, stall2, can_acc, found;
        int            gidx;
        logic [NR-1:0] e_ready, e_rv;
        ent_t          t;
        @(negedge clk);
        req_valid = v;
        rsp_ready = rr;
        rst_n     = rn;
        for (int i = 0; i < NR; i++) begin
            req_a[i*WA +: WA] = op_a[i];
            req_b[i*WB +: WB] = op_b[i];
        end
        #1;
        s2_full = (q.size() > 0) && q[0].in_s2;
        s1_full = (q.size() > 0) && !q[q.size()-1].in_s2;
        stall2  = s2_full && !rr;
        can_acc = rn && (!s1_full || !stall2);
        found   = 1'b0;
        gidx    = 0;
        for (int k = 0; k < NR; k++) begin
            if (!found && v[(m_ptr + k) % NR]) begin
                found = 1'b1;
                gidx  = (m_ptr + k) % NR;
            end
        end
        e_ready = (can_acc && found) ? (NR'(1) << gidx) : '0;
        e_rv    = s2_full ? (NR'(1) << q[0].owner) : '0;
        chk("req_ready", 32'(req_ready), 32'(e_ready));
        chk("rsp_valid", 32'(rsp_valid), 32'(e_rv));
        chk("rsp_y",     32'(rsp_y),     32'(m_y));
        chk("busy",      32'(busy),      32'(q.size() > 0));
        last_ready = req_ready;
        last_rv    = rsp_valid;
        last_y     = rsp_y;
        last_busy  = busy;
        if (!rn) begin
            q.delete();
            m_ptr = 0;
            m_y   = '0;
        end else begin
            if (s2_full && rr) void'(q.pop_front());
            if (s1_full && !stall2) begin
                t = q.pop_back();
                t.in_s2 = 1'b1;
                m_y = t.y;
                q.push_back(t);
            end
            if (can_acc && found) begin
                t.owner = gidx;
                t.y     = 16'(op_a[gidx]) * 16'(op_b[gidx]);
                t.in_s2 = 1'b0;
                q.push_back(t);
                m_ptr = (gidx + 1) % NR;
            end
        end
    endtask

    task automatic do_reset();
        step('0, 1'b1, 1'b0);
    endtask

    task automatic set_ops_ten();
        for (int i = 0; i < NR; i++) begin
            op_a[i] = WA'(i + 1);
            op_b[i] = 8'd10;
        end
    endtask

    typedef struct {
        int          id;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] y;
    } vec_t;
    vec_t tbl [4];

    int n_acc;
    logic [15:0] held_y;

    initial begin
        tbl[0] = '{id: 2, a: 8'hFF, b: 8'hFF, y: 16'hFE01};
        tbl[1] = '{id: 0, a: 8'h00, b: 8'hFF, y: 16'h0000};
        tbl[2] = '{id: 1, a: 8'h80, b: 8'h80, y: 16'h4000};
        tbl[3] = '{id: 3, a: 8'h12, b: 8'h34, y: 16'h03A8};

        rst_n = 1'b0; req_valid = '0; rsp_ready = 1'b0; req_a = '0; req_b = '0;
        for (int i = 0; i < NR; i++) begin op_a[i] = '0; op_b[i] = '0; end
        repeat (2) @(posedge clk);

        do_reset();
        chk("reset_req_ready", 32'(last_ready), 32'h0);
        chk("reset_rsp_valid", 32'(last_rv), 32'h0);
        chk("reset_rsp_y", 32'(last_y), 32'h0);
        chk("reset_busy", 32'(last_busy), 32'h0);

        // Single-request vectors, including the width extremes.
        for (int n = 0; n < 4; n++) begin
            for (int i = 0; i < NR; i++) begin op_a[i] = 8'h5A; op_b[i] = 8'hA5; end
            op_a[tbl[n].id] = tbl[n].a;
            op_b[tbl[n].id] = tbl[n].b;
            step(NR'(1) << tbl[n].id, 1'b1, 1'b1);
            chk($sformatf("vec%0d_ready", n), 32'(last_ready), 32'(NR'(1) << tbl[n].id));
            op_a[tbl[n].id] = 8'h33;
            step('0, 1'b1, 1'b1);
            chk($sformatf("vec%0d_s1_rv", n), 32'(last_rv), 32'h0);
            step('0, 1'b1, 1'b1);
            chk($sformatf("vec%0d_rv", n), 32'(last_rv), 32'(NR'(1) << tbl[n].id));
            chk($sformatf("vec%0d_y", n), 32'(last_y), 32'(tbl[n].y));
            step('0, 1'b1, 1'b1);
            chk($sformatf("vec%0d_busy", n), 32'(last_busy), 32'h0);
        end

        // Continuous streaming: round-robin grants, back-to-back results.
        do_reset();
        set_ops_ten();
        for (int n = 0; n < 10; n++) begin
            step('1, 1'b1, 1'b1);
            chk($sformatf("stream_grant%0d", n), 32'(last_ready), 32'(NR'(1) << (n % NR)));
            if (n >= 2) begin
                chk($sformatf("stream_owner%0d", n), 32'(last_rv), 32'(NR'(1) << ((n - 2) % NR)));
                chk($sformatf("stream_y%0d", n), 32'(last_y), 32'(10 * (((n - 2) % NR) + 1)));
            end
        end

        // Backpressure: two accepts fill both stages, then everything holds.
        do_reset();
        set_ops_ten();
        n_acc = 0;
        for (int n = 0; n < 5; n++) begin
            step('1, 1'b0, 1'b1);
            if (last_ready != '0) n_acc++;
            if (n == 2) held_y = last_y;
            if (n > 2) chk($sformatf("bp_y_hold%0d", n), 32'(last_y), 32'(held_y));
        end
        chk("bp_accepts", 32'(n_acc), 32'd2);
        chk("bp_held_y", 32'(held_y), 32'd10);
        step('0, 1'b1, 1'b1);
        chk("bp_drain0_rv", 32'(last_rv), 32'h1);
        chk("bp_drain0_y", 32'(last_y), 32'd10);
        step('0, 1'b1, 1'b1);
        chk("bp_drain1_rv", 32'(last_rv), 32'h2);
        chk("bp_drain1_y", 32'(last_y), 32'd20);
        step('0, 1'b1, 1'b1);
        chk("bp_empty_rv", 32'(last_rv), 32'h0);
        chk("bp_empty_busy", 32'(last_busy), 32'h0);

        // Fairness: after requester 0, the search from 1 reaches 3 before 0.
        do_reset();
        step(4'b0001, 1'b1, 1'b1);
        chk("fair_first", 32'(last_ready), 32'h1);
        step(4'b1001, 1'b1, 1'b1);
        chk("fair_wrap", 32'(last_ready), 32'h8);
        step(4'b1001, 1'b1, 1'b1);
        chk("fair_back", 32'(last_ready), 32'h1);

        // Reset with both stages full and stalled.
        do_reset();
        set_ops_ten();
        repeat (3) step('1, 1'b0, 1'b1);
        chk("rst_mid_busy_before", 32'(last_busy), 32'h1);
        step('1, 1'b0, 1'b0);
        chk("rst_mid_ready_low", 32'(last_ready), 32'h0);
        step(4'b0110, 1'b1, 1'b1);
        chk("rst_mid_rv", 32'(last_rv), 32'h0);
        chk("rst_mid_busy", 32'(last_busy), 32'h0);
        chk("rst_mid_y", 32'(last_y), 32'h0);
        chk("rst_mid_grant", 32'(last_ready), 32'h2);

        // Randomized traffic with operand churn, stalls and occasional resets.
        for (int n = 0; n < 2000; n++) begin
            for (int i = 0; i < NR; i++) begin
                op_a[i] = WA'($urandom);
                op_b[i] = WB'($urandom);
            end
            step(NR'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 63) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
